// File: rtl/set_assoc_l1.sv
// rtl/set_assoc_l1.sv - N-way set-associative write-through L1 cache
// Read-allocate with full-block refill; per-set round-robin victim, invalid ways preferred.
module set_assoc_l1 #(
   parameter int BSIZE = 8,
   parameter int NSETS = 256,
   parameter int NWAYS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addrFromProc,
   input  logic        enableFromProc,
   input  logic        writeFromProc,
   input  logic [31:0] dataFromProc,
   input  logic        invalidateFromProc,
   output logic [31:0] dataToProc,
   output logic        readyToProc,
   output logic [31:0] addrToLl,
   output logic        enableToLl,
   output logic        writeToLl,
   output logic [31:0] dataToLl,
   input  logic [31:0] dataFromLl,
   input  logic        readyFromLl,
   output logic [31:0] hitCount,
   output logic [31:0] missCount
);
   localparam int IBITS = $clog2(BSIZE);
   localparam int SBITS = $clog2(NSETS);
   localparam int TBITS = 30 - IBITS - SBITS;
   localparam int WBITS = (NWAYS > 1) ? $clog2(NWAYS) : 1;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

   state_t             state_q, state_d;
   logic [IBITS-1:0]   wcnt_q, wcnt_d;
   logic [WBITS-1:0]   victim_q, victim_d;
   logic [31:0]        hit_cnt_q, miss_cnt_q;
   logic [NSETS-1:0]   valid_q [NWAYS];
   logic [WBITS-1:0]   rr_q [NSETS];
   logic [TBITS-1:0]   tag_q [NWAYS][NSETS];
   logic [31:0]        data_q [NWAYS][NSETS*BSIZE];

   logic [IBITS-1:0]   word_a;
   logic [SBITS-1:0]   set_a;
   logic [TBITS-1:0]   tag_a;
   logic               hit;
   logic [WBITS-1:0]   hit_way, pick_way;
   logic               inv_all, hit_inc, miss_inc, clr_victim, refill_last, dwe;
   logic [WBITS-1:0]   dway;
   logic [IBITS-1:0]   dword;
   logic [31:0]        dwdata;
   logic               unused_addr;

   assign word_a      = addrFromProc[2 +: IBITS];
   assign set_a       = addrFromProc[2+IBITS +: SBITS];
   assign tag_a       = addrFromProc[31 -: TBITS];
   assign unused_addr = ^addrFromProc[1:0];

   // Descending scan so the lowest-index invalid way wins over the RR pointer.
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      pick_way = rr_q[set_a];
      for (int w = 0; w < NWAYS; w++) begin
         if (valid_q[w][set_a] && (tag_q[w][set_a] == tag_a)) begin
            hit     = 1'b1;
            hit_way = WBITS'(w);
         end
      end
      for (int w = NWAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][set_a]) pick_way = WBITS'(w);
      end
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      victim_d    = victim_q;
      readyToProc = 1'b0;
      enableToLl  = 1'b0;
      writeToLl   = 1'b0;
      addrToLl    = {addrFromProc[31:2], 2'b00};
      inv_all     = 1'b0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      clr_victim  = 1'b0;
      refill_last = 1'b0;
      dwe         = 1'b0;
      dway        = hit_way;
      dword       = word_a;
      case (state_q)
         IDLE: begin
            if (invalidateFromProc) begin
               inv_all = 1'b1;
            end else if (enableFromProc) begin
               if (writeFromProc) begin
                  state_d = WRITE;
               end else if (hit) begin
                  readyToProc = 1'b1;
                  hit_inc     = 1'b1;
               end else begin
                  miss_inc   = 1'b1;
                  victim_d   = pick_way;
                  wcnt_d     = '0;
                  clr_victim = 1'b1;
                  state_d    = REFILL;
               end
            end
         end
         REFILL: begin
            enableToLl = 1'b1;
            addrToLl   = {addrFromProc[31:2+IBITS], wcnt_q, 2'b00};
            if (readyFromLl) begin
               dwe    = 1'b1;
               dway   = victim_q;
               dword  = wcnt_q;
               wcnt_d = wcnt_q + IBITS'(1);
               if (&wcnt_q) begin
                  refill_last = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         WRITE: begin
            enableToLl  = 1'b1;
            writeToLl   = 1'b1;
            readyToProc = readyFromLl & enableFromProc;
            if (readyFromLl) begin
               dwe     = hit;
               state_d = IDLE;
            end
         end
         DONE: begin
            readyToProc = enableFromProc;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dwdata     = (state_q == REFILL) ? dataFromLl : dataFromProc;
   assign dataToLl   = dataFromProc;
   assign dataToProc = data_q[hit_way][{set_a, word_a}];
   assign hitCount   = hit_cnt_q;
   assign missCount  = miss_cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         victim_q   <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int w = 0; w < NWAYS; w++) valid_q[w] <= '0;
         for (int s = 0; s < NSETS; s++) rr_q[s] <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         victim_q <= victim_d;
         if (hit_inc && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (inv_all) begin
            for (int w = 0; w < NWAYS; w++) valid_q[w] <= '0;
         end
         // The victim stays invalid for the whole refill so a partial line never hits.
         if (clr_victim) valid_q[victim_d][set_a] <= 1'b0;
         if (refill_last) begin
            valid_q[victim_q][set_a] <= 1'b1;
            if (victim_q == rr_q[set_a]) begin
               rr_q[set_a] <= (rr_q[set_a] == WBITS'(NWAYS - 1)) ? '0 : rr_q[set_a] + WBITS'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (dwe) data_q[dway][{set_a, dword}] <= dwdata;
      if (refill_last) tag_q[victim_q][set_a] <= tag_a;
   end
endmodule
